// File: rtl/sync_fifo_pkg.sv
// Shared defaults and depth derivation for the single-clock FIFO.
// Imported by sync_fifo and sync_fifo_mem.
package sync_fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 3;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DSIZE register array, one write port, one combinational read port.
// Write lands on the rising edge. The array is not reset and has no flow control of its own.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO; a written word appears on rdata right after its write edge.
// Writes are dropped while wfull and reads while rempty. SYNC_FIFO_LEVEL_EN adds a level output.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic [DSIZE-1:0] rdata,
    input  logic             rinc,
    output logic             rempty
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    output logic [ASIZE:0]   level
`endif
);

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic [ASIZE:0] wptr_next;
    logic [ASIZE:0] rptr_next;
    logic           wr_en;
    logic           rd_en;
    logic           wfull_next;
    logic           rempty_next;

    assign wr_en = winc & ~wfull;
    assign rd_en = rinc & ~rempty;

    assign wptr_next = wptr + {{ASIZE{1'b0}}, wr_en};
    assign rptr_next = rptr + {{ASIZE{1'b0}}, rd_en};

    // Flags come from next-state pointers so they track occupancy with no lag.
    assign rempty_next = (wptr_next == rptr_next);
    assign wfull_next  = (wptr_next == {~rptr_next[ASIZE], rptr_next[ASIZE-1:0]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
            wfull  <= 1'b0;
        end else begin
            wptr   <= wptr_next;
            rptr   <= rptr_next;
            rempty <= rempty_next;
            wfull  <= wfull_next;
        end
    end

`ifdef SYNC_FIFO_LEVEL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= wptr_next - rptr_next;
        end
    end
`endif

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based occupancy model.
module tb_sync_fifo;

    localparam int DSIZE = 8;
    localparam int ASIZE = 3;
    localparam int DEPTH = 8;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic [DSIZE-1:0] wdata = '0;
    logic             winc  = 1'b0;
    logic             rinc  = 1'b0;
    logic             wfull;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
`ifdef SYNC_FIFO_LEVEL_EN
    logic [ASIZE:0]   level;
`endif

    int total = 0;
    int bad   = 0;
    logic [DSIZE-1:0] q[$];

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk    (clk),
        .rst    (rst),
        .wdata  (wdata),
        .winc   (winc),
        .wfull  (wfull),
        .rdata  (rdata),
        .rinc   (rinc),
        .rempty (rempty)
`ifdef SYNC_FIFO_LEVEL_EN
        ,
        .level  (level)
`endif
    );

    // One clock of stimulus; the queue model applies the FIFO rules at the edge.
    task automatic drive(input logic w, input logic [DSIZE-1:0] d, input logic r);
        bit do_w;
        bit do_r;
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge clk);
        do_w = w && (q.size() < DEPTH);
        do_r = r && (q.size() > 0);
        if (do_r) void'(q.pop_front());
        if (do_w) q.push_back(d);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (rempty !== 1'b1) begin bad++; $display("FAIL reset_rempty got=%b want=1", rempty); end
        total++; if (wfull !== 1'b0) begin bad++; $display("FAIL reset_wfull got=%b want=0", wfull); end
`ifdef SYNC_FIFO_LEVEL_EN
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
`endif
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_single();
        drive(1'b1, 8'h24, 1'b1);
        total++; if (rempty !== 1'b0) begin bad++; $display("FAIL single_rempty_after_write got=%b want=0", rempty); end
        total++; if (rdata !== 8'h24) begin bad++; $display("FAIL single_rdata got=%h want=24", rdata); end
        drive(1'b0, 8'h00, 1'b1);
        total++; if (rempty !== 1'b1) begin bad++; $display("FAIL single_rempty_after_pop got=%b want=1", rempty); end
    endtask

    task automatic test_fill();
        logic [DSIZE-1:0] d;
        for (int i = 0; i < 11; i++) begin
            d = (i < 8) ? DSIZE'(i) : ((i == 8) ? 8'hFF : DSIZE'(8'hA0 + i));
            drive(1'b1, d, 1'b0);
            total++; if (wfull !== (i >= 7)) begin bad++; $display("FAIL fill_wfull[%0d] got=%b want=%b", i, wfull, (i >= 7)); end
            total++; if (rempty !== 1'b0) begin bad++; $display("FAIL fill_rempty[%0d] got=%b want=0", i, rempty); end
`ifdef SYNC_FIFO_LEVEL_EN
            total++; if (level !== ASIZE'(0) + ((i < 8) ? i + 1 : 8)) begin bad++; $display("FAIL fill_level[%0d] got=%0d", i, level); end
`endif
        end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL fill_head got=%h want=00", rdata); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                total++; if (rdata !== DSIZE'(i)) begin bad++; $display("FAIL drain_rdata[%0d] got=%h want=%h", i, rdata, DSIZE'(i)); end
            end
            drive(1'b0, 8'h00, 1'b1);
            total++; if (rempty !== (i >= 7)) begin bad++; $display("FAIL drain_rempty[%0d] got=%b want=%b", i, rempty, (i >= 7)); end
            total++; if (wfull !== 1'b0) begin bad++; $display("FAIL drain_wfull[%0d] got=%b want=0", i, wfull); end
        end
        // Pops on empty must not move the read pointer: the next word is the one read.
        drive(1'b1, 8'hC3, 1'b0);
        total++; if (rdata !== 8'hC3 || rempty !== 1'b0) begin bad++; $display("FAIL drain_after_underflow got=%h/%b want=c3/0", rdata, rempty); end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_wrap();
        logic [DSIZE-1:0] d;
        for (int i = 0; i < 4; i++) drive(1'b1, DSIZE'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) begin
            total++; if (rdata !== q[0]) begin bad++; $display("FAIL wrap_rdata[%0d] got=%h want=%h", i, rdata, q[0]); end
            d = DSIZE'($urandom);
            drive(1'b1, d, 1'b1);
            total++; if (rempty !== 1'b0 || wfull !== 1'b0) begin bad++; $display("FAIL wrap_flags[%0d] got=%b%b want=00", i, rempty, wfull); end
`ifdef SYNC_FIFO_LEVEL_EN
            total++; if (level !== 4'd4) begin bad++; $display("FAIL wrap_level[%0d] got=%0d want=4", i, level); end
`endif
        end
        while (q.size() > 0) begin
            total++; if (rdata !== q[0]) begin bad++; $display("FAIL wrap_drain got=%h want=%h", rdata, q[0]); end
            drive(1'b0, 8'h00, 1'b1);
        end
        total++; if (rempty !== 1'b1) begin bad++; $display("FAIL wrap_end_rempty got=%b want=1", rempty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, DSIZE'(8'h10 + i), 1'b0);
        total++; if (wfull !== 1'b1) begin bad++; $display("FAIL simul_full_before got=%b want=1", wfull); end
        drive(1'b1, 8'h77, 1'b1);
        total++; if (wfull !== 1'b0) begin bad++; $display("FAIL simul_full_wfull got=%b want=0", wfull); end
        total++; if (rdata !== 8'h11) begin bad++; $display("FAIL simul_full_head got=%h want=11", rdata); end
        while (q.size() > 0) begin
            total++; if (rdata !== q[0]) begin bad++; $display("FAIL simul_drain got=%h want=%h", rdata, q[0]); end
            drive(1'b0, 8'h00, 1'b1);
        end
        total++; if (rempty !== 1'b1) begin bad++; $display("FAIL simul_empty_before got=%b want=1", rempty); end
        drive(1'b1, 8'h33, 1'b1);
        total++; if (rempty !== 1'b0 || rdata !== 8'h33) begin bad++; $display("FAIL simul_empty got=%b/%h want=0/33", rempty, rdata); end
        drive(1'b0, 8'h00, 1'b1);
        total++; if (rempty !== 1'b1) begin bad++; $display("FAIL simul_empty_pop got=%b want=1", rempty); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, DSIZE'(8'h90 + i), 1'b0);
        #3;
        rst = 1'b1;
        #1;
        total++; if (rempty !== 1'b1 || wfull !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b want=10", rempty, wfull); end
`ifdef SYNC_FIFO_LEVEL_EN
        total++; if (level !== '0) begin bad++; $display("FAIL midrst_level got=%0d want=0", level); end
`endif
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 8'h5A, 1'b0);
        total++; if (rdata !== 8'h5A || rempty !== 1'b0) begin bad++; $display("FAIL midrst_first got=%h/%b want=5a/0", rdata, rempty); end
        drive(1'b0, 8'h00, 1'b1);
        total++; if (rempty !== 1'b1) begin bad++; $display("FAIL midrst_pop got=%b want=1", rempty); end
    endtask

    task automatic test_random();
        int wbias;
        for (int i = 0; i < 600; i++) begin
            wbias = ((i / 100) % 2 == 0) ? 75 : 25;
            drive($urandom_range(0, 99) < wbias, DSIZE'($urandom), $urandom_range(0, 99) < 50);
            total++; if (rempty !== (q.size() == 0)) begin bad++; $display("FAIL rand_rempty[%0d] got=%b want=%b", i, rempty, (q.size() == 0)); end
            total++; if (wfull !== (q.size() == DEPTH)) begin bad++; $display("FAIL rand_wfull[%0d] got=%b want=%b", i, wfull, (q.size() == DEPTH)); end
            if (q.size() > 0) begin
                total++; if (rdata !== q[0]) begin bad++; $display("FAIL rand_rdata[%0d] got=%h want=%h", i, rdata, q[0]); end
            end
`ifdef SYNC_FIFO_LEVEL_EN
            total++; if (level !== (ASIZE+1)'(q.size())) begin bad++; $display("FAIL rand_level[%0d] got=%0d want=%0d", i, level, q.size()); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
